// File: rtl/system_sysid_pkg.sv
// Shared address map, CAPS field layout and reset values for the system ID block.
// The uptime feature is enabled by defining SYSTEM_SYSID_UPTIME_EN.
package system_sysid_pkg;

    localparam int ADDR_EXT_W = 9;

    localparam logic [ADDR_EXT_W-1:0] ADDR_SYSTEM_ID  = 9'd0;
    localparam logic [ADDR_EXT_W-1:0] ADDR_TIMESTAMP  = 9'd1;
    localparam logic [ADDR_EXT_W-1:0] ADDR_BUILD_WORD = 9'd2;
    localparam logic [ADDR_EXT_W-1:0] ADDR_CAPS       = 9'd3;
    localparam logic [ADDR_EXT_W-1:0] ADDR_SCRATCH    = 9'd4;
    localparam logic [ADDR_EXT_W-1:0] ADDR_UPTIME_LO  = 9'd5;
    localparam logic [ADDR_EXT_W-1:0] ADDR_UPTIME_HI  = 9'd6;
    localparam logic [ADDR_EXT_W-1:0] ADDR_CONTROL    = 9'd7;
    localparam logic [ADDR_EXT_W-1:0] ADDR_USER_BASE  = 9'd8;

    localparam int CAPS_UPTIME_BIT   = 0;
    localparam int CAPS_NUM_USER_LSB = 8;
    localparam int CAPS_ADDR_W_LSB   = 16;

    localparam logic [31:0] RST_WORD   = 32'h0000_0000;
    localparam logic [63:0] RST_UPTIME = 64'h0;

    function automatic logic [31:0] caps_word(input logic uptime_en, input int num_user,
                                              input int addr_w);
        logic [31:0] caps;
        caps = '0;
        caps[CAPS_UPTIME_BIT]          = uptime_en;
        caps[CAPS_NUM_USER_LSB +: 8]   = 8'(num_user);
        caps[CAPS_ADDR_W_LSB +: 8]     = 8'(addr_w);
        return caps;
    endfunction

endpackage

// File: rtl/system_sysid_uptime.sv
// Free-running 64-bit uptime counter with a high-word snapshot taken on low-word reads.
// Only instantiated when SYSTEM_SYSID_UPTIME_EN is defined.
module system_sysid_uptime
    import system_sysid_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        snap_i,
    output logic [31:0] count_lo_o,
    output logic [31:0] snap_hi_o
);

    logic [63:0] count_q, count_d;
    logic [31:0] snap_q, snap_d;

    // Clear takes priority over the per-cycle increment.
    always_comb begin
        count_d = clear_i ? RST_UPTIME : count_q + 64'd1;
        snap_d  = snap_i ? count_q[63:32] : snap_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= RST_UPTIME;
            snap_q  <= RST_WORD;
        end else begin
            count_q <= count_d;
            snap_q  <= snap_d;
        end
    end

    assign count_lo_o = count_q[31:0];
    assign snap_hi_o  = snap_q;

endmodule

// File: rtl/system_sysid_ext.sv
// Read-mostly system ID register file: constants, scratch, optional uptime, user ID words.
// Optional uptime counter is enabled by defining SYSTEM_SYSID_UPTIME_EN.
module system_sysid_ext
    import system_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID  = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP  = 32'd1456093976,
    parameter logic [31:0] BUILD_WORD = 32'h0001_0000,
    parameter int          ADDR_W     = 4,
    parameter int          NUM_USER   = 4,
    parameter logic [32*((NUM_USER > 0) ? NUM_USER : 1)-1:0] USER_WORDS = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

`ifdef SYSTEM_SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif
    localparam logic [31:0] CAPS_VALUE = caps_word(UPTIME_PRESENT, NUM_USER, ADDR_W);

    logic [ADDR_EXT_W-1:0] addr_ext;
    logic                  wr_en;
    logic [31:0]           rdata_d;
    logic [31:0]           readdata_q;
    logic                  valid_q;
    logic [31:0]           scratch_q, scratch_d;
    logic [31:0]           user_chain [NUM_USER+1];

    assign addr_ext = ADDR_EXT_W'(address);
    // A simultaneous read wins: the write is dropped.
    assign wr_en    = write & ~read;

    // Each mapped user word ORs in only when its address hits.
    assign user_chain[0] = '0;
    generate
        for (genvar gi = 0; gi < NUM_USER; gi++) begin : g_user
            assign user_chain[gi+1] = user_chain[gi] |
                ((addr_ext == ADDR_EXT_W'(int'(ADDR_USER_BASE) + gi)) ? USER_WORDS[32*gi +: 32] : 32'h0);
        end
    endgenerate

`ifdef SYSTEM_SYSID_UPTIME_EN
    logic [31:0] uptime_lo, uptime_hi;

    system_sysid_uptime u_uptime (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (wr_en && (addr_ext == ADDR_CONTROL) && writedata[0]),
        .snap_i     (read && (addr_ext == ADDR_UPTIME_LO)),
        .count_lo_o (uptime_lo),
        .snap_hi_o  (uptime_hi)
    );
`endif

    always_comb begin
        rdata_d = '0;
        case (addr_ext)
            ADDR_SYSTEM_ID:  rdata_d = SYSTEM_ID;
            ADDR_TIMESTAMP:  rdata_d = TIMESTAMP;
            ADDR_BUILD_WORD: rdata_d = BUILD_WORD;
            ADDR_CAPS:       rdata_d = CAPS_VALUE;
            ADDR_SCRATCH:    rdata_d = scratch_q;
`ifdef SYSTEM_SYSID_UPTIME_EN
            ADDR_UPTIME_LO:  rdata_d = uptime_lo;
            ADDR_UPTIME_HI:  rdata_d = uptime_hi;
`else
            ADDR_UPTIME_LO:  rdata_d = '0;
            ADDR_UPTIME_HI:  rdata_d = '0;
`endif
            ADDR_CONTROL:    rdata_d = '0;
            default:         rdata_d = user_chain[NUM_USER];
        endcase
    end

    always_comb begin
        scratch_d = (wr_en && (addr_ext == ADDR_SCRATCH)) ? writedata : scratch_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata_q <= RST_WORD;
            valid_q    <= 1'b0;
            scratch_q  <= RST_WORD;
        end else begin
            valid_q   <= read;
            scratch_q <= scratch_d;
            if (read) begin
                readdata_q <= rdata_d;
            end
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = valid_q;

endmodule
